// File: rtl/mcdf_pkg.sv
// Shared MCDF definitions: formatter state encoding, packet length constants
// and the length-select decode used by the arbiter, register block and formatter.
package mcdf_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REQ     = 2'd2,
      SEND    = 2'd3
   } fmt_state_e;

   localparam logic [5:0] PKGLEN_4  = 6'd4;
   localparam logic [5:0] PKGLEN_8  = 6'd8;
   localparam logic [5:0] PKGLEN_16 = 6'd16;
   localparam logic [5:0] PKGLEN_32 = 6'd32;

   // Reserved select codes 4-7 fall back to the longest packet.
   function automatic logic [5:0] pkglen_decode(input logic [2:0] sel);
      case (sel)
         3'd0:    return PKGLEN_4;
         3'd1:    return PKGLEN_8;
         3'd2:    return PKGLEN_16;
         default: return PKGLEN_32;
      endcase
   endfunction

endpackage

// File: rtl/mcdf_fmt_fifo.sv
// Single-clock packet buffer with registered read data; pointers wrap modulo DEPTH.
// Read data holds its value between reads so the formatter output stays put after a burst.
module mcdf_fmt_fifo
   import mcdf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int AW     = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;

   // Storage kept out of the reset domain so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         rdata      <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_en) begin
            rdata      <= mem[rd_ptr_reg];
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
      end
   end

endmodule

// File: rtl/mcdf_formatter.sv
// MCDF formatter: collects one arbiter packet into a buffer, requests the output
// bus, then replays the packet as a contiguous start/end framed burst.
module mcdf_formatter
   import mcdf_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 32,
   parameter int AW         = 5
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              a2f_val_i,
   input  logic [1:0]        a2f_id_i,
   input  logic [DATA_W-1:0] a2f_data_i,
   input  logic [2:0]        a2f_pkglen_sel_i,
   output logic              f2a_id_req_o,
   output logic              f2a_ack_o,
   input  logic              fmt_grant_i,
   output logic              fmt_req_o,
   output logic [1:0]        fmt_chid_o,
   output logic [5:0]        fmt_length_o,
   output logic [DATA_W-1:0] fmt_data_o,
   output logic              fmt_start_o,
   output logic              fmt_end_o
);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_COLLECT = COLLECT;
   localparam logic [1:0] ST_REQ     = REQ;
   localparam logic [1:0] ST_SEND    = SEND;

   logic [1:0] state_reg;
   logic [5:0] cnt_reg;
   logic [1:0] chid_reg;
   logic [5:0] len_reg;
   logic       start_reg;
   logic       end_reg;

   logic in_idle, in_collect, in_req, in_send;
   logic xfer, rd_en;

   assign in_idle    = (state_reg == ST_IDLE);
   assign in_collect = (state_reg == ST_COLLECT);
   assign in_req     = (state_reg == ST_REQ);
   assign in_send    = (state_reg == ST_SEND);

   // Handshakes are masked while reset is held so every output reads 0 at once.
   assign f2a_id_req_o = rstn_i & in_idle;
   assign f2a_ack_o    = rstn_i & (in_idle | in_collect);
   assign fmt_req_o    = rstn_i & in_req;

   assign xfer = a2f_val_i & f2a_ack_o;
   // The first read is issued on the grant edge so word 0 appears right after it.
   assign rd_en = (in_req & fmt_grant_i) | (in_send & (cnt_reg < len_reg));

   assign fmt_chid_o   = chid_reg;
   assign fmt_length_o = len_reg;
   assign fmt_start_o  = start_reg;
   assign fmt_end_o    = end_reg;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         chid_reg  <= '0;
         len_reg   <= '0;
         start_reg <= 1'b0;
         end_reg   <= 1'b0;
      end else begin
         start_reg <= 1'b0;
         end_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (xfer) begin
                  chid_reg  <= a2f_id_i;
                  len_reg   <= pkglen_decode(a2f_pkglen_sel_i);
                  cnt_reg   <= 6'd1;
                  state_reg <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (xfer) begin
                  if (cnt_reg == len_reg - 6'd1) begin
                     cnt_reg   <= '0;
                     state_reg <= ST_REQ;
                  end else begin
                     cnt_reg <= cnt_reg + 6'd1;
                  end
               end
            end
            ST_REQ: begin
               if (fmt_grant_i) begin
                  cnt_reg   <= 6'd1;
                  start_reg <= 1'b1;
                  state_reg <= ST_SEND;
               end
            end
            ST_SEND: begin
               // One extra SEND cycle after the last read lets fmt_end_o
               // show before the arbiter is asked for the next packet.
               if (cnt_reg < len_reg) begin
                  cnt_reg <= cnt_reg + 6'd1;
                  end_reg <= (cnt_reg == len_reg - 6'd1);
               end else begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   mcdf_fmt_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH),
      .AW     (AW)
   ) u_fifo (
      .clk   (clk_i),
      .rstn  (rstn_i),
      .wr_en (xfer),
      .wdata (a2f_data_i),
      .rd_en (rd_en),
      .rdata (fmt_data_o)
   );

endmodule

// File: tb/tb_mcdf_formatter.sv
// Directed bench for mcdf_formatter: table of packets plus hand-written
// sequences for held grant, mid-burst reset and back-to-back packets.
module tb_mcdf_formatter;

   logic        clk;
   logic        rstn;
   logic        a2f_val;
   logic [1:0]  a2f_id;
   logic [31:0] a2f_data;
   logic [2:0]  a2f_pkglen_sel;
   logic        f2a_id_req;
   logic        f2a_ack;
   logic        fmt_grant;
   logic        fmt_req;
   logic [1:0]  fmt_chid;
   logic [5:0]  fmt_length;
   logic [31:0] fmt_data;
   logic        fmt_start;
   logic        fmt_end;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  sel;
      logic [1:0]  id;
      logic [31:0] base;
      int          exp_len;
      bit          toggle;
      int          grant_wait;
      bit          val_hold;
   } pkt_t;

   pkt_t tbl [8];

   mcdf_formatter dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .a2f_val_i        (a2f_val),
      .a2f_id_i         (a2f_id),
      .a2f_data_i       (a2f_data),
      .a2f_pkglen_sel_i (a2f_pkglen_sel),
      .f2a_id_req_o     (f2a_id_req),
      .f2a_ack_o        (f2a_ack),
      .fmt_grant_i      (fmt_grant),
      .fmt_req_o        (fmt_req),
      .fmt_chid_o       (fmt_chid),
      .fmt_length_o     (fmt_length),
      .fmt_data_o       (fmt_data),
      .fmt_start_o      (fmt_start),
      .fmt_end_o        (fmt_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_id_req"}, 32'(f2a_id_req), 32'd0);
      check({tag, "_ack"},    32'(f2a_ack),    32'd0);
      check({tag, "_req"},    32'(fmt_req),    32'd0);
      check({tag, "_chid"},   32'(fmt_chid),   32'd0);
      check({tag, "_length"}, 32'(fmt_length), 32'd0);
      check({tag, "_data"},   fmt_data,        32'd0);
      check({tag, "_start"},  32'(fmt_start),  32'd0);
      check({tag, "_end"},    32'(fmt_end),    32'd0);
   endtask

   // Runs one packet end to end. abort_at>0 asserts reset before burst word abort_at.
   task automatic do_packet(input pkt_t p, input bit grant_held, input int abort_at);
      int sent;
      int cyc;
      bit phase;
      bit early_req;
      sent = 0;
      cyc = 0;
      phase = 1'b1;
      early_req = 1'b0;
      check("idle_id_req", 32'(f2a_id_req), 32'd1);
      while (sent < p.exp_len && cyc < 400) begin
         @(negedge clk);
         a2f_val        = p.toggle ? phase : 1'b1;
         phase          = ~phase;
         a2f_id         = (sent == 0) ? p.id : ~p.id;
         a2f_pkglen_sel = (sent == 0) ? p.sel : 3'd0;
         a2f_data       = p.base + 32'(sent);
         #1;
         if (fmt_req) early_req = 1'b1;
         if (a2f_val && f2a_ack) sent++;
         cyc++;
      end
      check("collect_words", 32'(sent), 32'(p.exp_len));
      check("req_before_last_word", 32'(early_req), 32'd0);

      @(negedge clk);
      a2f_val        = p.val_hold;
      a2f_id         = ~p.id;
      a2f_pkglen_sel = 3'd3;
      a2f_data       = 32'hDEAD_BEEF;
      #1;
      check("req_after_collect", 32'(fmt_req),    32'd1);
      check("ack_in_req",        32'(f2a_ack),    32'd0);
      check("id_req_in_req",     32'(f2a_id_req), 32'd0);
      check("chid",              32'(fmt_chid),   32'(p.id));
      check("length",            32'(fmt_length), 32'(p.exp_len));

      if (!grant_held) begin
         repeat (p.grant_wait) begin
            @(negedge clk);
            #1;
         end
         check("req_while_waiting", 32'(fmt_req), 32'd1);
         fmt_grant = 1'b1;
      end

      for (int i = 0; i < p.exp_len; i++) begin
         @(negedge clk);
         if (!grant_held) fmt_grant = 1'b0;
         if (abort_at > 0 && i == abort_at) begin
            rstn = 1'b0;
            #1;
            check_all_zero("mid_send_reset");
            $display("pkt id=%0d len=%0d aborted by reset after %0d words", p.id, p.exp_len, i);
            return;
         end
         #1;
         check("burst_data",  fmt_data,          p.base + 32'(i));
         check("burst_start", 32'(fmt_start),    32'(i == 0));
         check("burst_end",   32'(fmt_end),      32'(i == p.exp_len - 1));
         check("burst_req",   32'(fmt_req),      32'd0);
         check("burst_ack",   32'(f2a_ack),      32'd0);
         check("burst_chid",  32'(fmt_chid),     32'(p.id));
      end

      @(negedge clk);
      a2f_val = 1'b0;
      #1;
      check("post_id_req", 32'(f2a_id_req), 32'd1);
      check("post_end",    32'(fmt_end),    32'd0);
      check("post_start",  32'(fmt_start),  32'd0);
      check("post_data",   fmt_data,        p.base + 32'(p.exp_len - 1));
      $display("pkt id=%0d sel=%0d len=%0d burst done, errors so far %0d",
               p.id, p.sel, p.exp_len, errors);
   endtask

   initial begin
      pkt_t t4;
      pkt_t t5a;
      pkt_t t5b;

      //          sel   id     base          len toggle gw hold
      tbl[0] = '{3'd0, 2'd2, 32'h0000_0010,  4, 1'b0, 2, 1'b0};
      tbl[1] = '{3'd3, 2'd1, 32'h0000_0100, 32, 1'b1, 1, 1'b0};
      tbl[2] = '{3'd5, 2'd3, 32'h0000_0200, 32, 1'b0, 0, 1'b0};
      tbl[3] = '{3'd1, 2'd0, 32'h0000_0300,  8, 1'b0, 3, 1'b0};
      tbl[4] = '{3'd2, 2'd1, 32'h0000_0400, 16, 1'b1, 0, 1'b0};
      tbl[5] = '{3'd7, 2'd2, 32'h0000_0500, 32, 1'b0, 0, 1'b0};
      tbl[6] = '{3'd0, 2'd0, 32'hA000_0000,  4, 1'b0, 1, 1'b1};
      tbl[7] = '{3'd1, 2'd1, 32'hB000_0000,  8, 1'b0, 1, 1'b0};
      t4     = '{3'd1, 2'd3, 32'h0000_0800,  8, 1'b0, 0, 1'b1};
      t5a    = '{3'd2, 2'd3, 32'h0000_0600, 16, 1'b0, 1, 1'b0};
      t5b    = '{3'd0, 2'd1, 32'h0000_0700,  4, 1'b0, 1, 1'b0};

      rstn           = 1'b0;
      a2f_val        = 1'b0;
      a2f_id         = 2'd0;
      a2f_data       = 32'd0;
      a2f_pkglen_sel = 3'd0;
      fmt_grant      = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("release_id_req", 32'(f2a_id_req), 32'd1);
      check("release_ack",    32'(f2a_ack),    32'd1);

      for (int k = 0; k < 8; k++) begin
         do_packet(tbl[k], 1'b0, 0);
      end

      // Grant held high: no effect in IDLE/COLLECT, exactly one burst.
      fmt_grant = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("held_grant_idle_req",   32'(fmt_req),    32'd0);
      check("held_grant_idle_start", 32'(fmt_start),  32'd0);
      check("held_grant_id_req",     32'(f2a_id_req), 32'd1);
      do_packet(t4, 1'b1, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check("held_grant_no_rerun_start", 32'(fmt_start), 32'd0);
         check("held_grant_no_rerun_req",   32'(fmt_req),   32'd0);
      end
      fmt_grant = 1'b0;

      // Reset mid-burst, then a clean packet with fresh data.
      do_packet(t5a, 1'b0, 3);
      a2f_val = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("after_reset_id_req", 32'(f2a_id_req), 32'd1);
      check("after_reset_data",   fmt_data,        32'd0);
      do_packet(t5b, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
